// File: rtl/s_machine_pkg.sv
// Shared definitions for the data memory access unit: widths, op codes,
// sequencer states and small op classification helpers.
package s_machine_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_PUSH  = 2'b10,
        OP_POP   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PARK,
        ST_ACCESS,
        ST_DONE
    } state_t;

    // True for ops that write the memory when they do not error.
    function automatic logic op_writes(input op_t op);
        return (op == OP_STORE) || (op == OP_PUSH);
    endfunction

    // True for ops that return memory data when they do not error.
    function automatic logic op_reads(input op_t op);
        return (op == OP_LOAD) || (op == OP_POP);
    endfunction

endpackage

// File: rtl/data_mem_access_unit_if.sv
// Request/response handshake between the control unit (master) and the
// data memory access unit (slave).
interface data_mem_access_unit_if #(
    parameter int unsigned ADDR_W = s_machine_pkg::ADDR_W,
    parameter int unsigned DATA_W = s_machine_pkg::DATA_W
);

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid,
        input  req_ready,
        output req_op,
        output req_addr,
        output req_wdata,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_op,
        input  req_addr,
        input  req_wdata,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );

endinterface

// File: rtl/data_mem_access_unit_stack_pointer_ctrl.sv
// Data stack pointer: holds sp, resolves the access target for an incoming
// request and reports full/empty. The stack grows downward from STACK_BASE.
module stack_pointer_ctrl
    import s_machine_pkg::op_t;
    import s_machine_pkg::OP_PUSH;
    import s_machine_pkg::OP_POP;
#(
    parameter int unsigned          ADDR_W      = s_machine_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0]    STACK_BASE  = 8'hFF,
    parameter logic [ADDR_W-1:0]    STACK_LIMIT = 8'hC0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  op_t               op,
    input  logic [ADDR_W-1:0] addr,
    input  logic              step_en,
    input  op_t               step_op,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] target,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W-1:0] FULL_SP = STACK_LIMIT - 1'b1;

    logic [ADDR_W-1:0] sp_next;

    assign full  = (sp == FULL_SP);
    assign empty = (sp == STACK_BASE);

    // Target address: sp for PUSH, slot above sp for POP, else the request address.
    always_comb begin
        target = addr;
        unique case (op)
            OP_PUSH: target = sp;
            OP_POP:  target = sp + 1'b1;
            default: target = addr;
        endcase
    end

    // Next sp for the op being retired.
    always_comb begin
        sp_next = sp;
        unique case (step_op)
            OP_PUSH: sp_next = sp - 1'b1;
            OP_POP:  sp_next = sp + 1'b1;
            default: sp_next = sp;
        endcase
    end

    // sp register, stepped once per successful stack op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp <= STACK_BASE;
        end else if (step_en) begin
            sp <= sp_next;
        end
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// Sequencer between the control unit and the address-triggered DataMemory.
// Every access parks the address on target^1 for one cycle so the memory
// sees an address change even when the same location is accessed twice.
module data_mem_access_unit
    import s_machine_pkg::op_t;
    import s_machine_pkg::state_t;
    import s_machine_pkg::OP_LOAD;
    import s_machine_pkg::OP_PUSH;
    import s_machine_pkg::OP_POP;
    import s_machine_pkg::ST_IDLE;
    import s_machine_pkg::ST_PARK;
    import s_machine_pkg::ST_ACCESS;
    import s_machine_pkg::ST_DONE;
    import s_machine_pkg::op_writes;
    import s_machine_pkg::op_reads;
#(
    parameter int unsigned       ADDR_W      = s_machine_pkg::ADDR_W,
    parameter int unsigned       DATA_W      = s_machine_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] STACK_BASE  = 8'hFF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'hC0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    data_mem_access_unit_if.slave  bus,
    output logic [ADDR_W-1:0]      sp,
    output logic                   mem_read_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);

    localparam logic [ADDR_W-1:0] PARK_FLIP = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    op_t               req_op_c;
    op_t               op_q;
    logic [ADDR_W-1:0] target_c;
    logic [ADDR_W-1:0] target_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_c;
    logic              err_q;
    logic              full;
    logic              empty;
    logic              step_en;

    assign req_op_c = op_t'(bus.req_op);
    assign err_c    = ((req_op_c == OP_PUSH) && full) || ((req_op_c == OP_POP) && empty);
    // sp moves on the DONE->IDLE edge, only for stack ops that did not fault.
    assign step_en  = (state == ST_DONE) && !err_q;

    stack_pointer_ctrl #(
        .ADDR_W      (ADDR_W),
        .STACK_BASE  (STACK_BASE),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_stack_pointer_ctrl (
        .clk     (clk),
        .reset_n (reset_n),
        .op      (req_op_c),
        .addr    (bus.req_addr),
        .step_en (step_en),
        .step_op (op_q),
        .sp      (sp),
        .target  (target_c),
        .full    (full),
        .empty   (empty)
    );

    // Request sequencer; all handshake and memory pins are registered and
    // loaded on the edge that enters the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            op_q           <= OP_LOAD;
            target_q       <= '0;
            wdata_q        <= '0;
            err_q          <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_rdata  <= '0;
            bus.rsp_err    <= 1'b0;
            mem_read_write <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q           <= req_op_c;
                        target_q       <= target_c;
                        wdata_q        <= bus.req_wdata;
                        err_q          <= err_c;
                        bus.req_ready  <= 1'b0;
                        mem_read_write <= 1'b0;
                        mem_addr       <= target_c ^ PARK_FLIP;
                        state          <= ST_PARK;
                    end
                end
                ST_PARK: begin
                    mem_addr       <= target_q;
                    mem_wdata      <= wdata_q;
                    mem_read_write <= op_writes(op_q) && !err_q;
                    state          <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    mem_read_write <= 1'b0;
                    bus.rsp_valid  <= 1'b1;
                    bus.rsp_err    <= err_q;
                    bus.rsp_rdata  <= (op_reads(op_q) && !err_q) ? mem_rdata : '0;
                    state          <= ST_DONE;
                end
                ST_DONE: begin
                    bus.rsp_valid  <= 1'b0;
                    bus.rsp_err    <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
